// File: rtl/audio_pkg.sv
// Shared constants and types for the Pocket I2S audio path.
// Defaults match a 12.288 MHz MCLK driving a 48 kHz stereo DAC.
package audio_pkg;

   localparam int AUDIO_SAMPLE_WIDTH = 16;
   localparam int AUDIO_SCLK_DIV     = 4;
   localparam int AUDIO_SLOT_BITS    = 32;
   localparam int AUDIO_FRAME_CLKS   = AUDIO_SCLK_DIV * 2 * AUDIO_SLOT_BITS;

   typedef struct packed {
      logic [AUDIO_SAMPLE_WIDTH-1:0] left;
      logic [AUDIO_SAMPLE_WIDTH-1:0] right;
   } audio_pair_t;

endpackage

// File: rtl/audio_i2s_tx_if.sv
// Stereo sample handshake into the I2S serializer.
// The producer drives a left/right pair qualified by valid; ready means holding is empty.
interface audio_i2s_tx_if
   import audio_pkg::*;
#(
   parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH
);

   logic [SAMPLE_WIDTH-1:0] sample_l;
   logic [SAMPLE_WIDTH-1:0] sample_r;
   logic                    sample_valid;
   logic                    sample_ready;

   modport master (
      output sample_l,
      output sample_r,
      output sample_valid,
      input  sample_ready
   );

   modport slave (
      input  sample_l,
      input  sample_r,
      input  sample_valid,
      output sample_ready
   );

endinterface

// File: rtl/audio_i2s_bitclk_gen.sv
// SCLK divider and frame bit counter for the I2S transmitter.
// SCLK and LRCK are registered so the DAC sees glitch-free edges.
module audio_i2s_bitclk_gen
   import audio_pkg::*;
#(
   parameter int SCLK_DIV  = AUDIO_SCLK_DIV,
   parameter int SLOT_BITS = AUDIO_SLOT_BITS,
   localparam int DW = $clog2(SCLK_DIV),
   localparam int BW = $clog2(2 * SLOT_BITS)
) (
   input  logic          clk,
   input  logic          rst,
   output logic          sclk,
   output logic          lrck,
   output logic          bit_tick,
   output logic          frame_tick,
   output logic [BW-1:0] bit_pos
);

   localparam logic [DW-1:0] D_LAST = DW'(SCLK_DIV - 1);
   localparam logic [DW-1:0] D_HALF = DW'(SCLK_DIV / 2);
   localparam logic [BW-1:0] B_LAST = BW'(2 * SLOT_BITS - 1);
   localparam logic [BW-1:0] B_SLOT = BW'(SLOT_BITS);

   logic [DW-1:0] d;
   logic [DW-1:0] d_nxt;
   logic [BW-1:0] b_nxt;

   always_comb begin
      bit_tick   = (d == D_LAST);
      frame_tick = bit_tick && (bit_pos == B_LAST);
      d_nxt      = bit_tick ? '0 : d + 1'b1;
      b_nxt      = bit_pos;
      if (bit_tick) begin
         b_nxt = frame_tick ? '0 : bit_pos + 1'b1;
      end
   end

   // Outputs are computed from next state so they align with d and bit_pos.
   always_ff @(posedge clk) begin
      if (rst) begin
         d       <= '0;
         bit_pos <= B_LAST;
         sclk    <= 1'b0;
         lrck    <= 1'b1;
      end else begin
         d       <= d_nxt;
         bit_pos <= b_nxt;
         sclk    <= (d_nxt >= D_HALF);
         lrck    <= (b_nxt >= B_SLOT);
      end
   end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S serializer for the Pocket audio DAC: sample handshake, frame shadow,
// MSB-first shift mux with one-SCLK I2S delay, and a saturating underrun counter.
module audio_i2s_tx
   import audio_pkg::*;
#(
   parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
   parameter int SCLK_DIV     = AUDIO_SCLK_DIV,
   parameter int SLOT_BITS    = AUDIO_SLOT_BITS,
   parameter int UNDERRUN_W   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   audio_i2s_tx_if.slave         snd,
   output logic                  dac_sclk,
   output logic                  dac_lrck,
   output logic                  dac_sdata,
   output logic                  frame_start,
   output logic [UNDERRUN_W-1:0] underrun_count
);

   localparam int BW = $clog2(2 * SLOT_BITS);
   localparam logic [BW-1:0] SLOT = BW'(SLOT_BITS);

   logic                    bit_tick;
   logic                    frame_tick;
   logic [BW-1:0]           bit_pos;
   logic [BW-1:0]           nxt;
   logic [BW-1:0]           b;
   logic                    right;
   logic                    bit_val;
   logic                    accept;
   logic                    hold_full;
   logic [SAMPLE_WIDTH-1:0] hold_l;
   logic [SAMPLE_WIDTH-1:0] hold_r;
   logic [SAMPLE_WIDTH-1:0] shadow_l;
   logic [SAMPLE_WIDTH-1:0] shadow_r;
   logic [SAMPLE_WIDTH-1:0] s;
   logic [SAMPLE_WIDTH-1:0] sh;

   audio_i2s_bitclk_gen #(
      .SCLK_DIV  (SCLK_DIV),
      .SLOT_BITS (SLOT_BITS)
   ) u_bitclk (
      .clk        (clk),
      .rst        (rst),
      .sclk       (dac_sclk),
      .lrck       (dac_lrck),
      .bit_tick   (bit_tick),
      .frame_tick (frame_tick),
      .bit_pos    (bit_pos)
   );

   assign snd.sample_ready = ~hold_full;
   assign accept           = snd.sample_valid && !hold_full;

   // Bit for the position about to start; slot bit 0 is the I2S delay bit.
   always_comb begin
      nxt     = frame_tick ? '0 : bit_pos + 1'b1;
      right   = (nxt >= SLOT);
      b       = right ? nxt - SLOT : nxt;
      s       = right ? shadow_r : shadow_l;
      sh      = s << (b - 1'b1);
      bit_val = (b != '0) && (int'(b) <= SAMPLE_WIDTH) && sh[SAMPLE_WIDTH-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_full      <= 1'b0;
         hold_l         <= '0;
         hold_r         <= '0;
         shadow_l       <= '0;
         shadow_r       <= '0;
         dac_sdata      <= 1'b0;
         frame_start    <= 1'b0;
         underrun_count <= '0;
      end else begin
         frame_start <= frame_tick;
         if (bit_tick) begin
            dac_sdata <= bit_val;
         end
         // Load sees pre-accept state: an accept on this edge is an underrun.
         if (frame_tick) begin
            if (hold_full) begin
               shadow_l <= hold_l;
               shadow_r <= hold_r;
            end else if (underrun_count != '1) begin
               underrun_count <= underrun_count + 1'b1;
            end
         end
         if (accept) begin
            hold_l    <= snd.sample_l;
            hold_r    <= snd.sample_r;
            hold_full <= 1'b1;
         end else if (frame_tick && hold_full) begin
            hold_full <= 1'b0;
         end
      end
   end

endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- I2S serializer for the Pocket audio DAC.
- Runs directly on the 12.288 MHz audio output of the core PLL; that clock is also the DAC MCLK.
- Accepts stereo 16-bit samples through a valid/ready handshake.
- Generates SCLK (3.072 MHz), LRCK (48 kHz) and serial data in standard I2S framing: 64 SCLK per frame, 32-bit slots, MSB one SCLK after each LRCK edge.
- Samples arriving from the CPU domain are synchronized upstream, so this block has a single clock.

Parameters:
- SAMPLE_WIDTH, 16: bits per channel sample; must be ≤ 31.
- SCLK_DIV, 4: clk cycles per SCLK period; must be even and ≥ 2.
- SLOT_BITS, 32: SCLK cycles per channel slot; a frame is 2*SLOT_BITS.
- UNDERRUN_W, 8: width of the saturating underrun counter.

Ports:
- clk  in  1  12.288 MHz audio clock from the PLL.
- rst  in  1  synchronous, active-high reset.
- sample_l  in  SAMPLE_WIDTH  left sample, two's complement.
- sample_r  in  SAMPLE_WIDTH  right sample, two's complement.
- sample_valid  in  1  sample pair is presented.
- sample_ready  out  1  holding register is empty.
- dac_sclk  out  1  bit clock.
- dac_lrck  out  1  word select; 0 = left, 1 = right.
- dac_sdata  out  1  serial data.
- frame_start  out  1  one-cycle pulse when a new frame loads.
- underrun_count  out  UNDERRUN_W  saturating count of frames with no new sample.

Behaviour:
- **Clock and reset.** One clock (clk). Reset is synchronous and active-high (rst).
- **Divider.** Counter d runs 0..SCLK_DIV-1 and wraps. dac_sclk = 1 when d ≥ SCLK_DIV/2, else 0. The "bit tick" is the cycle where d == SCLK_DIV-1; the next cycle is the SCLK falling edge.
- **Bit counter.** bit_cnt runs 0..2*SLOT_BITS-1, advances on every bit tick, and wraps from 63 to 0. dac_lrck = (bit_cnt ≥ SLOT_BITS), driven from registered state.
- **Data.**
  - dac_sdata is registered and updated on the bit tick with the value for the new bit_cnt.
  - Let b = slot position and s = that slot's shadow sample.
  - If 1 ≤ b ≤ SAMPLE_WIDTH, output s[SAMPLE_WIDTH-b]; otherwise output 0.
  - Data therefore changes only on SCLK falling edges and is stable on rising edges.
- **Holding register.**
  - sample_ready = ~hold_full.
  - On sample_valid && sample_ready, latch both channels and set hold_full.
- **Frame load.** Occurs on the bit tick where bit_cnt goes 63 → 0.
  - If hold_full: copy the holding register to the shadow, clear hold_full, and pulse frame_start on the following cycle.
  - Else: keep the previous shadow (repeat last sample), increment underrun_count saturating at all-ones, and still pulse frame_start.
- **Simultaneous accept and load while empty.** The load evaluates the pre-accept state, so it is an underrun. The new pair lands in holding and plays in the next frame.
- **Load while full.** sample_ready is 0, so nothing is accepted that cycle. sample_ready rises on the next cycle.
- **Latency.** An accepted pair begins on dac_sdata at the next frame boundary: from ≥1 up to 256 clk after acceptance, plus one SCLK for the I2S delay.
- **Reset values.**
  - d = 0, bit_cnt = 63, hold_full = 0, shadow = 0.
  - Outputs: dac_sclk 0, dac_lrck 1, dac_sdata 0, sample_ready 1, frame_start 0, underrun_count 0.
  - The first frame load occurs on the 4th clk after reset release.
- **Reset mid-frame.** All state returns to the reset values within one cycle. A sample pending in holding is discarded.
- **Frame rate.** One frame = SCLK_DIV*2*SLOT_BITS = 256 clk, i.e. 48 kHz at 12.288 MHz.

Decomposition:
- **Shared package audio_pkg:**
  - constants AUDIO_SCLK_DIV = 4, AUDIO_SLOT_BITS = 32, AUDIO_FRAME_CLKS = 256;
  - typedef for a stereo sample pair (left/right, SAMPLE_WIDTH each).
- **Sub-module audio_i2s_bitclk_gen:**
  - contains the divider and bit counter;
  - outputs dac_sclk, dac_lrck, bit_tick, frame_tick and the bit position.
- **Top level:** handshake, shadow, shift mux and underrun counter.

Test Plan:
1. **Reset and timing.** Release rst and hold sample_valid=0. Required:
   - dac_sclk period 4 clk, high for 2;
   - dac_lrck period 256 clk, 128 clk high/low;
   - first frame_start 5 clk after release;
   - underrun_count increments on every frame.
2. **Single pair serialization.** Present L=16'hA5F0, R=16'h0F0F before the first load. Sample dac_sdata on SCLK rising edges. Required:
   - left bits 1..16 = 1010_0101_1111_0000, bits 0 and 17..31 = 0;
   - right slot = 0000_1111_0000_1111;
   - dac_lrck 0 during left.
3. **Back-pressure.** Hold sample_valid=1 with an incrementing pattern. Required:
   - exactly one pair accepted per frame;
   - sample_ready low from acceptance until the cycle after each load;
   - no pattern skipped or repeated over 10 frames;
   - underrun_count stays at 1, from the initial frame only.
4. **Simultaneous accept and load.** Assert valid for the first time exactly on the 63→0 bit tick with holding empty. Required:
   - underrun_count +1;
   - the previous sample repeats;
   - the new pair appears in the following frame.
5. **Underrun saturation.** Run 300 frames with no samples. Required: underrun_count == 255 and holds; the last sample repeats continuously.
6. **Mid-frame reset.** Assert rst during bit_cnt=40 with holding full. Required:
   - reset values on the next cycle;
   - the pending pair is discarded, so the first post-reset frame outputs zeros.
